// File: rtl/inst_mem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: bus widths, memory size,
// response-owner encoding and the address range check.
package inst_mem_arbiter_pkg;

    localparam int unsigned INST_ADDR_BUS_W   = 32;
    localparam int unsigned INST_BUS_W        = 32;
    localparam int unsigned INST_MEM_NUM_LOG2 = 12;
    localparam logic [INST_BUS_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        RSP_NONE  = 2'd0,
        RSP_FETCH = 2'd1,
        RSP_LOAD  = 2'd2
    } rsp_e;

    // Any address bit above the word-address field marks the access out of range.
    function automatic logic addr_oor(input logic [INST_ADDR_BUS_W-1:0] addr,
                                      input int unsigned                aw);
        return (addr >> (aw + 2)) != '0;
    endfunction

endpackage

// File: rtl/inst_mem_arbiter_if.sv
// Fetch, loader and memory-side signals of the instruction-memory arbiter.
// The slave modport is the arbiter's view; master is the requesters/RAM view.
interface inst_mem_arbiter_if
    import inst_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = INST_MEM_NUM_LOG2
);
    logic                       fetch_req_i;
    logic [INST_ADDR_BUS_W-1:0] fetch_addr_i;
    logic                       fetch_flush_i;
    logic                       fetch_gnt_o;
    logic                       fetch_rvalid_o;
    logic [INST_BUS_W-1:0]      fetch_rdata_o;
    logic                       fetch_err_o;

    logic                       ld_req_i;
    logic                       ld_we_i;
    logic [INST_ADDR_BUS_W-1:0] ld_addr_i;
    logic [INST_BUS_W-1:0]      ld_wdata_i;
    logic                       ld_gnt_o;
    logic                       ld_rvalid_o;
    logic [INST_BUS_W-1:0]      ld_rdata_o;
    logic                       ld_err_o;

    logic                       mem_ce_o;
    logic                       mem_we_o;
    logic [ADDR_W-1:0]          mem_addr_o;
    logic [INST_BUS_W-1:0]      mem_wdata_o;
    logic [INST_BUS_W-1:0]      mem_rdata_i;

    modport slave (
        input  fetch_req_i, fetch_addr_i, fetch_flush_i,
        output fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, fetch_err_o,
        input  ld_req_i, ld_we_i, ld_addr_i, ld_wdata_i,
        output ld_gnt_o, ld_rvalid_o, ld_rdata_o, ld_err_o,
        output mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output fetch_req_i, fetch_addr_i, fetch_flush_i,
        input  fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, fetch_err_o,
        output ld_req_i, ld_we_i, ld_addr_i, ld_wdata_i,
        input  ld_gnt_o, ld_rvalid_o, ld_rdata_o, ld_err_o,
        input  mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );

endinterface

// File: rtl/inst_mem_arbiter.sv
// Shares the single-port instruction RAM between core fetch and the program loader.
// Loader has priority; a starvation counter forces a fetch grant after STARVE_MAX loader wins.
module inst_mem_arbiter
    import inst_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = INST_MEM_NUM_LOG2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    inst_mem_arbiter_if.slave   bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    rsp_e       r_rsp;
    logic       r_err;
    logic       r_ld_we;
    logic [3:0] r_starve_cnt;

    rsp_e       w_rsp_nxt;
    logic       w_err_nxt;
    logic       w_ld_we_nxt;
    logic [3:0] w_starve_nxt;

    logic w_fetch_live;
    logic w_force_fetch;
    logic w_fetch_gnt;
    logic w_ld_gnt;
    logic w_fetch_oor;
    logic w_ld_oor;

    assign w_fetch_live  = bus.fetch_req_i & ~bus.fetch_flush_i;
    assign w_force_fetch = w_fetch_live & (r_starve_cnt == STARVE_LIM);
    assign w_ld_gnt      = ~rst & bus.ld_req_i & ~w_force_fetch;
    assign w_fetch_gnt   = ~rst & w_fetch_live & (~bus.ld_req_i | w_force_fetch);
    assign w_fetch_oor   = addr_oor(bus.fetch_addr_i, ADDR_W);
    assign w_ld_oor      = addr_oor(bus.ld_addr_i, ADDR_W);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp        <= RSP_NONE;
            r_err        <= 1'b0;
            r_ld_we      <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            r_rsp        <= w_rsp_nxt;
            r_err        <= w_err_nxt;
            r_ld_we      <= w_ld_we_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Next state: response owner follows this cycle's grant; starvation counter
    always_comb begin
        w_rsp_nxt    = RSP_NONE;
        w_err_nxt    = 1'b0;
        w_ld_we_nxt  = 1'b0;
        w_starve_nxt = r_starve_cnt;

        if (w_ld_gnt) begin
            w_rsp_nxt   = RSP_LOAD;
            w_err_nxt   = w_ld_oor;
            w_ld_we_nxt = bus.ld_we_i;
        end else if (w_fetch_gnt) begin
            w_rsp_nxt   = RSP_FETCH;
            w_err_nxt   = w_fetch_oor;
        end

        if (w_fetch_gnt || !w_fetch_live) begin
            w_starve_nxt = '0;
        end else if (w_ld_gnt && (r_starve_cnt != STARVE_LIM)) begin
            w_starve_nxt = r_starve_cnt + 4'd1;
        end
    end

    // Outputs: grants, memory drive, and one-cycle responses (gated by rst so a
    // response pending at reset never appears)
    always_comb begin
        bus.fetch_gnt_o    = w_fetch_gnt;
        bus.ld_gnt_o       = w_ld_gnt;

        bus.mem_ce_o       = 1'b0;
        bus.mem_we_o       = 1'b0;
        bus.mem_addr_o     = '0;
        bus.mem_wdata_o    = '0;

        bus.fetch_rvalid_o = 1'b0;
        bus.fetch_rdata_o  = ZERO_WORD;
        bus.fetch_err_o    = 1'b0;
        bus.ld_rvalid_o    = 1'b0;
        bus.ld_rdata_o     = ZERO_WORD;
        bus.ld_err_o       = 1'b0;

        if (w_ld_gnt && !w_ld_oor) begin
            bus.mem_ce_o    = 1'b1;
            bus.mem_we_o    = bus.ld_we_i;
            bus.mem_addr_o  = bus.ld_addr_i[ADDR_W+1:2];
            bus.mem_wdata_o = bus.ld_wdata_i;
        end else if (w_fetch_gnt && !w_fetch_oor) begin
            bus.mem_ce_o    = 1'b1;
            bus.mem_addr_o  = bus.fetch_addr_i[ADDR_W+1:2];
        end

        if (!rst) begin
            case (r_rsp)
                RSP_FETCH: begin
                    if (!bus.fetch_flush_i) begin
                        bus.fetch_rvalid_o = 1'b1;
                        bus.fetch_err_o    = r_err;
                        bus.fetch_rdata_o  = r_err ? ZERO_WORD : bus.mem_rdata_i;
                    end
                end
                RSP_LOAD: begin
                    bus.ld_rvalid_o = 1'b1;
                    bus.ld_err_o    = r_err;
                    bus.ld_rdata_o  = (r_err || r_ld_we) ? ZERO_WORD : bus.mem_rdata_i;
                end
                default: ;
            endcase
        end
    end

    a_one_grant: assert property (@(posedge clk) !(bus.fetch_gnt_o && bus.ld_gnt_o));
    a_we_has_ce: assert property (@(posedge clk) bus.mem_we_o |-> bus.mem_ce_o);

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Scoreboard bench for inst_mem_arbiter: directed stimulus pushes expected responses,
// a negedge monitor pops and compares them against the fetch and loader response ports.
module tb_inst_mem_arbiter;
    import inst_mem_arbiter_pkg::*;

    localparam int unsigned AW = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_mem_arbiter_if #(.ADDR_W(AW)) bus();

    inst_mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural single-port synchronous RAM (inst_ram_sp); unwritten word i reads 0xA500_0000|i
    logic [31:0] ram     [0:(1<<AW)-1];
    bit          written [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_ce_o) begin
            bus.mem_rdata_i <= written[bus.mem_addr_o] ? ram[bus.mem_addr_o]
                                                       : (32'hA500_0000 | 32'(bus.mem_addr_o));
            if (bus.mem_we_o) begin
                ram[bus.mem_addr_o]     <= bus.mem_wdata_o;
                written[bus.mem_addr_o] <= 1'b1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rsp_t;

    rsp_t fq[$];
    rsp_t lq[$];
    rsp_t fe, le;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: a response is expected exactly in the cycle recorded at grant time
    always @(negedge clk) begin
        logic f_exp, l_exp;
        f_exp = (fq.size() > 0) && (fq[0].cyc == cyc);
        chk("fetch_rvalid", bus.fetch_rvalid_o, f_exp);
        if (f_exp) begin
            fe = fq.pop_front();
            chk("fetch_rdata", bus.fetch_rdata_o, fe.data);
            chk("fetch_err", bus.fetch_err_o, fe.err);
        end else begin
            chk("fetch_idle_out", {bus.fetch_rdata_o, bus.fetch_err_o}, 0);
        end

        l_exp = (lq.size() > 0) && (lq[0].cyc == cyc);
        chk("ld_rvalid", bus.ld_rvalid_o, l_exp);
        if (l_exp) begin
            le = lq.pop_front();
            chk("ld_rdata", bus.ld_rdata_o, le.data);
            chk("ld_err", bus.ld_err_o, le.err);
        end else begin
            chk("ld_idle_out", {bus.ld_rdata_o, bus.ld_err_o}, 0);
        end
    end

    task automatic drive(input logic fr, input logic [31:0] fa, input logic ff,
                         input logic lr, input logic lwe, input logic [31:0] la,
                         input logic [31:0] lwd);
        bus.fetch_req_i   = fr;
        bus.fetch_addr_i  = fa;
        bus.fetch_flush_i = ff;
        bus.ld_req_i      = lr;
        bus.ld_we_i       = lwe;
        bus.ld_addr_i     = la;
        bus.ld_wdata_i    = lwd;
    endtask

    task automatic expect_cyc(input string tag, input logic fg, input logic lg,
                              input logic ce, input logic we,
                              input logic [AW-1:0] addr, input logic [31:0] wdata);
        #3;
        chk({tag, "_fetch_gnt"}, bus.fetch_gnt_o, fg);
        chk({tag, "_ld_gnt"},    bus.ld_gnt_o, lg);
        chk({tag, "_mem_ce"},    bus.mem_ce_o, ce);
        chk({tag, "_mem_we"},    bus.mem_we_o, we);
        chk({tag, "_mem_addr_wdata"}, {bus.mem_addr_o, bus.mem_wdata_o}, {addr, wdata});
    endtask

    task automatic pf(input logic [31:0] d, input logic e);
        fq.push_back('{data: d, err: e, cyc: cyc + 1});
    endtask

    task automatic pl(input logic [31:0] d, input logic e);
        lq.push_back('{data: d, err: e, cyc: cyc + 1});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_cyc("idle", 1'b0, 1'b0, 1'b0, 1'b0, '0, 32'h0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Requests during reset receive no grant
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0);
            expect_cyc("in_rst", 1'b0, 1'b0, 1'b0, 1'b0, '0, 32'h0);
            tick();
        end
        rst = 1'b0;
        idle();

        // Fetch-only stream
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            expect_cyc("fstream", 1'b1, 1'b0, 1'b1, 1'b0, AW'(i), 32'h0);
            pf(32'hA500_0000 | 32'(i), 1'b0);
            tick();
        end
        idle();

        // Loader write then read back
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        expect_cyc("ld_wr", 1'b0, 1'b1, 1'b1, 1'b1, AW'(4), 32'hDEAD_BEEF);
        pl(32'h0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        expect_cyc("ld_rd", 1'b0, 1'b1, 1'b1, 1'b0, AW'(4), 32'h0);
        pl(32'hDEAD_BEEF, 1'b0);
        tick();
        idle();

        // Contention: four loader grants, fetch forced on the fifth, then loader again
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h30, 32'h0);
            if (k == 4) begin
                expect_cyc("cont_f", 1'b1, 1'b0, 1'b1, 1'b0, AW'(8), 32'h0);
                pf(32'hA500_0008, 1'b0);
            end else begin
                expect_cyc("cont_l", 1'b0, 1'b1, 1'b1, 1'b0, AW'(12), 32'h0);
                pl(32'hA500_000C, 1'b0);
            end
            tick();
        end
        idle();

        // Out-of-range and address boundaries
        drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_cyc("f_oor", 1'b1, 1'b0, 1'b0, 1'b0, '0, 32'h0);
        pf(32'h0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0001_0000, 32'h1234_5678);
        expect_cyc("ld_oor", 1'b0, 1'b1, 1'b0, 1'b0, '0, 32'h0);
        pl(32'h0, 1'b1);
        tick();
        drive(1'b1, 32'h0000_0FFC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_cyc("f_top", 1'b1, 1'b0, 1'b1, 1'b0, AW'(10'h3FF), 32'h0);
        pf(32'hA500_03FF, 1'b0);
        tick();
        drive(1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_cyc("f_oor_edge", 1'b1, 1'b0, 1'b0, 1'b0, '0, 32'h0);
        pf(32'h0, 1'b1);
        tick();
        drive(1'b1, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_cyc("f_lowbits", 1'b1, 1'b0, 1'b1, 1'b0, AW'(1), 32'h0);
        pf(32'hA500_0001, 1'b0);
        tick();
        idle();

        // Flush: response dropped, grant blocked, loader unaffected
        drive(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_cyc("fl_req", 1'b1, 1'b0, 1'b1, 1'b0, AW'(1), 32'h0);
        tick();
        drive(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_cyc("fl_block", 1'b0, 1'b0, 1'b0, 1'b0, '0, 32'h0);
        tick();
        drive(1'b1, 32'h8, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0);
        expect_cyc("fl_ld", 1'b0, 1'b1, 1'b1, 1'b0, AW'(2), 32'h0);
        pl(32'hA500_0002, 1'b0);
        tick();
        idle();

        // Reset mid-operation: pending loader response discarded, counter cleared
        drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0);
        expect_cyc("rm_l0", 1'b0, 1'b1, 1'b1, 1'b0, AW'(1), 32'h0);
        pl(32'hA500_0001, 1'b0);
        tick();
        expect_cyc("rm_l1", 1'b0, 1'b1, 1'b1, 1'b0, AW'(1), 32'h0);
        tick();
        rst = 1'b1;
        expect_cyc("rm_rst", 1'b0, 1'b0, 1'b0, 1'b0, '0, 32'h0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                expect_cyc("rm_f", 1'b1, 1'b0, 1'b1, 1'b0, '0, 32'h0);
                pf(32'hA500_0000, 1'b0);
            end else begin
                expect_cyc("rm_l", 1'b0, 1'b1, 1'b1, 1'b0, AW'(1), 32'h0);
                pl(32'hA500_0001, 1'b0);
            end
            tick();
        end
        idle();
        idle();

        chk("queues_drained", 64'(fq.size() + lq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_mem_arbiter.md
Name: inst_mem_arbiter

Overview:
- Shares the single-port, synchronous-read instruction memory between two requesters:
  - the core fetch port (read-only);
  - the program-loader/debug port (read/write), used to download code over UART/JTAG.
- Sits between the IF stage / loader and the instruction RAM. Grants one access per cycle and returns a one-cycle-latency response to the requester that owns it.
- Loader has priority; a starvation guard protects fetch.

Parameters:
- ADDR_W, `InstMemNumLog2, word-address width of the instruction memory.
- STARVE_MAX, 4, consecutive loader grants allowed while fetch waits (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- fetch_req_i  in  1  fetch access request
- fetch_addr_i  in  32  fetch byte address (`InstAddrBus)
- fetch_flush_i  in  1  pipeline flush; drop fetch activity
- fetch_gnt_o  out  1  fetch request accepted this cycle
- fetch_rvalid_o  out  1  fetch response valid
- fetch_rdata_o  out  32  fetched instruction (`InstBus)
- fetch_err_o  out  1  fetch response is an out-of-range error
- ld_req_i  in  1  loader access request
- ld_we_i  in  1  1 = write, 0 = read
- ld_addr_i  in  32  loader byte address
- ld_wdata_i  in  32  loader write data
- ld_gnt_o  out  1  loader request accepted this cycle
- ld_rvalid_o  out  1  loader response/ack valid
- ld_rdata_o  out  32  loader read data
- ld_err_o  out  1  loader response is an out-of-range error
- mem_ce_o  out  1  memory enable
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory word address
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data, valid the cycle after ce

Behaviour:
- Grant logic (combinational, same cycle as the request):
  - ld_gnt_o = ld_req_i and not force_fetch.
  - fetch_gnt_o = fetch_req_i and not fetch_flush_i and (not ld_req_i or force_fetch).
  - force_fetch = fetch_req_i and not fetch_flush_i and starve_cnt == STARVE_MAX.
  - At most one grant per cycle.
- Address decode:
  - Word address = addr[ADDR_W+1:2]; addr[1:0] is ignored.
  - Any set bit in addr[31:ADDR_W+2] makes the access out-of-range: mem_ce_o stays 0, the grant is still given, and the response carries err = 1 with rdata = `ZeroWord.
- Memory drive (only for a granted in-range access):
  - mem_ce_o = 1; mem_we_o = ld_we_i for a loader grant, 0 for a fetch grant.
  - mem_addr_o and mem_wdata_o come from the granted port.
  - With no grant: mem_ce_o = 0, mem_we_o = 0, address and data don't-care (drive 0).
- Response owner register rsp_q: states RSP_NONE, RSP_FETCH, RSP_LOAD, plus a registered err_q.
  - Next state = owner of this cycle's grant, else RSP_NONE. It updates every cycle, so no stall is possible.
- Response outputs (the cycle after the grant, one cycle wide):
  - RSP_FETCH: fetch_rvalid_o = 1; fetch_rdata_o = mem_rdata_i, or 0 if err_q.
  - RSP_LOAD: ld_rvalid_o = 1; ld_rdata_o = mem_rdata_i for reads, 0 for writes or err_q.
  - Both rdata outputs are 0 when their rvalid is low.
- Flush:
  - fetch_flush_i in the response cycle forces fetch_rvalid_o = 0 and fetch_err_o = 0.
  - The memory read still happened; it is harmless.
  - Flush in the request cycle blocks the fetch grant.
  - Loader traffic is unaffected by flush.
- Starvation counter starve_cnt (4 bits):
  - Increments on a loader grant while fetch_req_i = 1 and flush = 0, saturating at STARVE_MAX.
  - Clears on a fetch grant, or in any cycle with fetch_req_i = 0 or a flush.
- Simultaneous first requests: the loader wins unless force_fetch.
- Back-to-back grants are allowed every cycle, including alternating owners.
- Reset (synchronous):
  - rsp_q = RSP_NONE, err_q = 0, starve_cnt = 0.
  - All outputs are 0 the cycle after rst.
  - A response pending at reset is discarded, with no rvalid afterwards.
  - Grants are 0 while rst = 1.

Decomposition:
- Shared package/defines (yadan_defs):
  - existing: `InstAddrBus, `InstBus, `ZeroWord, `InstMemNumLog2;
  - new: `RspNone = 2'd0, `RspFetch = 2'd1, `RspLoad = 2'd2.
- No sub-module needed; the counter and the response FSM are inline.
- The bench uses a behavioural single-port synchronous RAM model, inst_ram_sp.

Test Plan:
- Fetch-only stream: fetch_req high, addr 0x0, 0x4, 0x8 on consecutive cycles → gnt each cycle; rvalid cycles 1..3 with RAM words 0, 1, 2.
- Loader write then read: write 0xDEADBEEF to 0x10, then read 0x10 → ld_rvalid twice; second ld_rdata = 0xDEADBEEF; mem_we pulses once.
- Contention with STARVE_MAX = 4: both requesters held high → loader granted 4 cycles, fetch on the 5th, counter clears, loader again.
- Out-of-range: fetch addr 0x8000_0000 → fetch_gnt = 1, mem_ce = 0, next cycle rvalid = 1, err = 1, rdata = 0.
- Flush in response cycle: fetch granted at cycle N, fetch_flush_i at N+1 → fetch_rvalid = 0 at N+1; a flush at N blocks the grant.
- Reset mid-operation: loader read granted, rst asserted next cycle → no ld_rvalid; all outputs 0; starve_cnt = 0 on release.
